// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: FSM state codes and default counter width.
// Also used by the register file to decode state_o.
package wdt_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_INTP  = 2'b10,
    ST_RST   = 2'b11
  } wdt_state_e;

endpackage

// File: rtl/wdt_rst_pulse.sv
// Watchdog reset pulse generator: a start strobe yields a registered
// pulse exactly RST_CYCLES clocks long; last flags its final cycle.
module wdt_rst_pulse #(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic pulse,
  output logic last
);

  localparam int unsigned PW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PW-1:0] LAST_CNT = PW'(RST_CYCLES - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = LAST_CNT;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse = busy_q;
  assign last  = busy_q && (cnt_q == '0);

endmodule

// File: rtl/wdt_countdown.sv
// Watchdog timeout counter: tick-driven countdown with a two-stage
// expiry (interrupt first, then a reset pulse if still pending).
module wdt_countdown
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             cnt_tick,
  input  logic             wdt_en,
  input  logic             rst_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             feed,
  input  logic             int_clr,
  output logic [CNT_W-1:0] cnt_val,
  output logic             wdt_int,
  output logic             wdt_rst,
  output logic [1:0]       state_o
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_q, int_d;
  logic             pulse_start;
  logic             pulse_last;

  wdt_rst_pulse #(
    .RST_CYCLES(RST_CYCLES)
  ) u_pulse (
    .clk  (pclk),
    .rst_n(presetn),
    .start(pulse_start),
    .pulse(wdt_rst),
    .last (pulse_last)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    int_d       = int_q;
    pulse_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wdt_en) begin
          cnt_d   = load_val;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT, ST_INTP: begin
        // disable > int_clr > feed > tick
        if (!wdt_en) begin
          state_d = ST_IDLE;
          int_d   = 1'b0;
        end else if (int_clr) begin
          cnt_d   = load_val;
          int_d   = 1'b0;
          state_d = ST_COUNT;
        end else if (feed) begin
          cnt_d = load_val;
        end else if (cnt_tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (state_q == ST_COUNT) begin
            int_d   = 1'b1;
            cnt_d   = load_val;
            state_d = ST_INTP;
          end else if (rst_en) begin
            pulse_start = 1'b1;
            state_d     = ST_RST;
          end else begin
            cnt_d = load_val;
          end
        end
      end
      ST_RST: begin
        if (pulse_last) begin
          int_d   = 1'b0;
          cnt_d   = load_val;
          state_d = wdt_en ? ST_COUNT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
    end
  end

  assign cnt_val = cnt_q;
  assign wdt_int = int_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_wdt_countdown.sv
// Self-checking bench for wdt_countdown: reference model compared every
// cycle, plus directed checks with literal expectations.
module tb_wdt_countdown;

  localparam int RST_CYCLES = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic        cnt_tick = 1'b0;
  logic        wdt_en = 1'b0;
  logic        rst_en = 1'b0;
  logic [15:0] load_val = 16'd0;
  logic        feed = 1'b0;
  logic        int_clr = 1'b0;
  logic [15:0] cnt_val;
  logic        wdt_int;
  logic        wdt_rst;
  logic [1:0]  state_o;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  wdt_countdown #(
    .CNT_W(16),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .cnt_tick(cnt_tick),
    .wdt_en  (wdt_en),
    .rst_en  (rst_en),
    .load_val(load_val),
    .feed    (feed),
    .int_clr (int_clr),
    .cnt_val (cnt_val),
    .wdt_int (wdt_int),
    .wdt_rst (wdt_rst),
    .state_o (state_o)
  );

  always #5 pclk = ~pclk;

  // Model: mode 0 idle, 1 counting, 2 interrupt pending, 3 reset pulse.
  int          m_mode;
  logic [15:0] m_cnt;
  bit          m_int;
  int          m_left;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_mode <= 0;
      m_cnt  <= 16'd0;
      m_int  <= 1'b0;
      m_left <= 0;
    end else if (m_mode == 0) begin
      if (wdt_en) begin
        m_cnt  <= load_val;
        m_mode <= 1;
      end
    end else if (m_mode == 3) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_int  <= 1'b0;
        m_cnt  <= load_val;
        m_mode <= wdt_en ? 1 : 0;
      end
    end else if (!wdt_en) begin
      m_mode <= 0;
      m_int  <= 1'b0;
    end else if (int_clr && m_mode == 2) begin
      m_mode <= 1;
      m_int  <= 1'b0;
      m_cnt  <= load_val;
    end else if (int_clr || feed) begin
      m_cnt <= load_val;
    end else if (cnt_tick) begin
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 16'd1;
      end else if (m_mode == 1) begin
        m_int  <= 1'b1;
        m_cnt  <= load_val;
        m_mode <= 2;
      end else if (rst_en) begin
        m_mode <= 3;
        m_left <= RST_CYCLES;
      end else begin
        m_cnt <= load_val;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge pclk) begin
    if (chk_en) begin
      check("model cnt_val", 32'(cnt_val), 32'(m_cnt));
      check("model wdt_int", 32'(wdt_int), 32'(m_int));
      check("model wdt_rst", 32'(wdt_rst), 32'(m_left > 0));
      check("model state", 32'(state_o), 32'(m_mode));
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #2;
  endtask

  task automatic tick();
    repeat (7) cyc();
    cnt_tick = 1'b1;
    cyc();
    cnt_tick = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int cnt, input int irq,
                            input int rst, input int st);
    check({tag, " cnt_val"}, 32'(cnt_val), 32'(cnt));
    check({tag, " wdt_int"}, 32'(wdt_int), 32'(irq));
    check({tag, " wdt_rst"}, 32'(wdt_rst), 32'(rst));
    check({tag, " state"}, 32'(state_o), 32'(st));
  endtask

  task automatic measure_pulse(input string tag);
    int len;
    len = wdt_rst ? 1 : 0;
    for (int i = 0; i < 40 && wdt_rst; i++) begin
      cyc();
      if (wdt_rst) len++;
    end
    check({tag, " pulse length"}, 32'(len), 32'(RST_CYCLES));
  endtask

  initial begin
    #1 presetn = 1'b0;
    repeat (3) cyc();
    expect_out("reset", 0, 0, 0, 0);
    presetn = 1'b1;
    chk_en  = 1'b1;

    // Basic timeout, no reset stage.
    load_val = 16'd3;
    wdt_en   = 1'b1;
    cyc();
    expect_out("load", 3, 0, 0, 1);
    tick(); check("t1 cnt", 32'(cnt_val), 32'd2);
    tick(); check("t2 cnt", 32'(cnt_val), 32'd1);
    tick(); check("t3 cnt", 32'(cnt_val), 32'd0);
    tick(); expect_out("t4 expiry", 3, 1, 0, 2);
    repeat (4) tick();
    expect_out("intp reload", 3, 1, 0, 2);

    // Disable while interrupt pending.
    wdt_en = 1'b0;
    cyc();
    expect_out("disable", 3, 0, 0, 0);
    tick();
    tick();
    expect_out("idle ticks", 3, 0, 0, 0);

    // Two-stage expiry into reset pulse.
    load_val = 16'd2;
    rst_en   = 1'b1;
    wdt_en   = 1'b1;
    cyc();
    repeat (3) tick();
    expect_out("tick3 int", 2, 1, 0, 2);
    repeat (3) tick();
    expect_out("tick6 rst", 0, 1, 1, 3);
    measure_pulse("rst");
    expect_out("after pulse", 2, 0, 0, 1);

    // Feed wins over a coincident timeout; new load value taken.
    tick();
    tick();
    check("pre-feed cnt", 32'(cnt_val), 32'd0);
    load_val = 16'd1;
    feed     = 1'b1;
    cnt_tick = 1'b1;
    cyc();
    feed     = 1'b0;
    cnt_tick = 1'b0;
    expect_out("feed prio", 1, 0, 0, 1);

    // int_clr wins over a coincident second expiry.
    tick();
    tick();
    expect_out("intp again", 1, 1, 0, 2);
    tick();
    int_clr  = 1'b1;
    cnt_tick = 1'b1;
    cyc();
    int_clr  = 1'b0;
    cnt_tick = 1'b0;
    expect_out("clr prio", 1, 0, 0, 1);

    // Zero load, then disable during the pulse.
    wdt_en = 1'b0;
    cyc();
    load_val = 16'd0;
    wdt_en   = 1'b1;
    cyc();
    tick();
    expect_out("zero t1", 0, 1, 0, 2);
    tick();
    expect_out("zero t2", 0, 1, 1, 3);
    wdt_en = 1'b0;
    measure_pulse("rst dis");
    expect_out("pulse to idle", 0, 0, 0, 0);

    // Asynchronous reset mid-pulse.
    wdt_en = 1'b1;
    cyc();
    tick();
    tick();
    repeat (4) cyc();
    check("pre-async rst", 32'(wdt_rst), 32'd1);
    #1 presetn = 1'b0;
    #1 expect_out("async", 0, 0, 0, 0);
    cyc();
    presetn = 1'b1;
    wdt_en  = 1'b0;
    repeat (2) cyc();
    expect_out("post async", 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/wdt_countdown.md
Name: wdt_countdown

Overview:
- Consumer end of the watchdog count-tick interface. Takes the single-pclk-cycle tick produced by the watchdog clock divider and decrements a programmable timeout counter on each tick.
- Two-stage timeout. The first expiry raises an interrupt and reloads the counter. A second expiry with the interrupt still pending asserts a watchdog reset pulse.
- Sits between the divider and the APB register file, which supplies load value, enables, feed and interrupt-clear strobes.

Parameters:
- CNT_W, 16, width of timeout counter and load value.
- RST_CYCLES, 16, wdt_rst pulse length in pclk cycles (>=1).

Ports:
- pclk  input  1  APB clock, all logic on rising edge.
- presetn  input  1  asynchronous active-low reset.
- cnt_tick  input  1  count enable from divider; one pclk cycle high per tick.
- wdt_en  input  1  level; 1 = watchdog running.
- rst_en  input  1  level; 1 = second expiry asserts wdt_rst.
- load_val  input  CNT_W  timeout reload value.
- feed  input  1  one-cycle strobe; reload counter.
- int_clr  input  1  one-cycle strobe; clear interrupt and reload counter.
- cnt_val  output  CNT_W  current counter value, registered.
- wdt_int  output  1  interrupt, registered level.
- wdt_rst  output  1  reset request pulse, registered.
- state_o  output  2  current FSM state, for status readback.

Behaviour:
- Clock and reset: one clock (pclk); reset is asynchronous, active-low (presetn).
- Reset values: cnt_val=0, wdt_int=0, wdt_rst=0, state=IDLE, pulse counter=0.
- FSM states:
  - IDLE(00): counter frozen, outputs low. wdt_en=1 -> cnt_val<=load_val, go to COUNT on the next edge.
  - COUNT(01): on cnt_tick with cnt_val!=0, decrement by 1. On cnt_tick with cnt_val==0: wdt_int<=1, cnt_val<=load_val, go to INTP.
  - INTP(10): keep counting as in COUNT.
    - On cnt_tick with cnt_val==0 and rst_en=1: go to RST, wdt_rst<=1, pulse counter<=RST_CYCLES-1.
    - On cnt_tick with cnt_val==0 and rst_en=0: reload, stay in INTP, wdt_int stays 1.
  - RST(11): wdt_rst held high exactly RST_CYCLES pclk cycles. Ticks, feed and int_clr are ignored. At pulse end: wdt_rst<=0, wdt_int<=0, cnt_val<=load_val, go to COUNT if wdt_en=1, else IDLE.
- feed in COUNT/INTP: cnt_val<=load_val next edge. wdt_int is unchanged.
- int_clr in INTP: wdt_int<=0, cnt_val<=load_val, go to COUNT. In COUNT, int_clr acts as feed.
- Priority in the same cycle, COUNT/INTP: int_clr > feed > cnt_tick. A timeout coincident with feed or int_clr does not fire.
- wdt_en=0 in COUNT/INTP: go to IDLE next edge, wdt_int<=0, cnt_val held. In RST, wdt_en=0 does not truncate the pulse.
- load_val=0: expiry on the first tick after entering COUNT.
- Arithmetic:
  - Decrement is unsigned, never wraps below 0; zero is detected before decrement.
  - load_val is sampled only at reload events.
- Latency: all outputs update one pclk edge after the causing input.
- presetn low mid-operation, including mid-pulse: immediate return to reset values.

Decomposition:
- Shared package wdt_pkg: 2-bit state encodings (ST_IDLE, ST_COUNT, ST_INTP, ST_RST) and the default CNT_W, reused by the register file for state_o decode.
- One sub-module is natural: wdt_rst_pulse, an RST_CYCLES down-counter generating the reset pulse from a start strobe. Everything else stays in wdt_countdown.

Test Plan:
- Basic timeout:
  - Stimulus: load_val=3, wdt_en=1, rst_en=0, tick every 8 cycles.
  - Response: cnt_val 3->2->1->0; wdt_int rises on the 4th tick with cnt_val=3; no wdt_rst ever.
- Reset pulse:
  - Stimulus: rst_en=1, load_val=2, no int_clr.
  - Response: wdt_int on tick 3; wdt_rst on tick 6, high exactly 16 cycles; then wdt_int=0, state=COUNT, cnt_val=2.
- Feed and clear priority:
  - Stimulus: feed on the same cycle as the tick at cnt_val=0.
  - Response: no interrupt, cnt_val=load_val.
  - Stimulus: int_clr with tick at cnt_val=0 in INTP.
  - Response: no wdt_rst, wdt_int=0, state=COUNT.
- Disable:
  - Stimulus: wdt_en=0 in INTP.
  - Response: next edge state=IDLE, wdt_int=0, cnt_val frozen; ticks ignored.
  - Stimulus: wdt_en=0 during RST.
  - Response: full 16-cycle pulse, then IDLE.
- Zero load:
  - Stimulus: load_val=0, rst_en=1.
  - Response: wdt_int on the first tick, wdt_rst on the second.
- Async reset:
  - Stimulus: presetn low mid-pulse (cycle 5 of 16), no clock edge.
  - Response: wdt_rst, wdt_int and cnt_val drop to 0 immediately; state=IDLE.
